// File: rtl/plinko_pkg.sv
// plinko_pkg: shared types, constants and helpers for the Plinko board blocks.
package plinko_pkg;
    typedef enum logic [1:0] {IDLE, FALL, LAND} state_t;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int NUM_ROWS = 7;
    localparam int BIN_W = 3;
    localparam int COUNT_W = 5;

    function automatic logic [BIN_W-1:0] popcount7(input logic [NUM_ROWS-1:0] v);
        logic [BIN_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_ROWS; i++)
            c = c + BIN_W'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit right-shift Galois LFSR; a zero seed falls back to the default.
module lfsr16
    import plinko_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    always_ff @(posedge clk)
        q <= rst ? (seed == '0 ? DEFAULT_SEED : seed) : (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
endmodule

// File: rtl/ball_dropper.sv
// ball_dropper: launches LFSR-chosen peg paths, animates each ball row by row and
// strobes the landed path to the bin counter, capping total drops at MAX_BALLS.
module ball_dropper
    import plinko_pkg::*;
#(
    parameter int          ROW_CYCLES = 4,
    parameter int          MAX_BALLS  = 31,
    parameter logic [15:0] SEED       = 16'hACE1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                auto_en,
    output logic [NUM_ROWS-1:0] rand_choice,
    output logic                ball_valid,
    output logic                busy,
    output logic [BIN_W-1:0]    row,
    output logic [BIN_W-1:0]    pos,
    output logic [COUNT_W-1:0]  balls_dropped,
    output logic                full
);
    localparam int TW = $clog2(ROW_CYCLES + 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(ROW_CYCLES - 1);
    localparam logic [BIN_W-1:0] LAST_ROW = BIN_W'(NUM_ROWS - 1);
    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_BALLS);

    state_t state, state_n;
    logic [TW-1:0] tick;
    logic [15:0] lfsr;
    logic launch, tick_tc;
    logic [NUM_ROWS-1:0] mask;

    lfsr16 u_lfsr (.clk(clk), .rst(rst), .seed(SEED), .q(lfsr));

    assign full = balls_dropped == MAX_CNT;

    always_comb begin
        launch  = state == IDLE && (start || auto_en) && !full;
        tick_tc = tick == TICK_MAX;
        state_n = launch ? FALL
                : (state == FALL && tick_tc && row == LAST_ROW) ? LAND
                : state == LAND ? IDLE
                : state;
        // rows already passed during FALL, the whole path once landed
        mask = state == LAND ? '1
             : state == FALL ? NUM_ROWS'((8'd1 << row) - 8'd1)
             : '0;
        pos = popcount7(rand_choice & mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tick          <= '0;
            row           <= '0;
            rand_choice   <= '0;
            balls_dropped <= '0;
            busy          <= 1'b0;
            ball_valid    <= 1'b0;
        end else begin
            state      <= state_n;
            busy       <= state_n != IDLE;
            ball_valid <= state_n == LAND;
            if (launch) begin
                rand_choice <= lfsr[NUM_ROWS-1:0];
                row         <= '0;
                tick        <= '0;
            end else if (state == FALL) begin
                tick <= tick_tc ? '0 : tick + 1'b1;
                if (tick_tc)
                    row <= row == LAST_ROW ? '0 : row + 1'b1;
            end
            if (state == LAND && balls_dropped != MAX_CNT)
                balls_dropped <= balls_dropped + 1'b1;
        end
    end
endmodule

// File: tb/tb_ball_dropper.sv
// tb_ball_dropper: directed scenarios on three configurations of ball_dropper.
module tb_ball_dropper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic a_start = 0, a_auto = 0, b_start = 0, b_auto = 0, c_start = 0, c_auto = 0;
    logic [6:0] a_rc, b_rc, c_rc;
    logic a_bv, a_busy, a_full, b_bv, b_busy, b_full, c_bv, c_busy, c_full;
    logic [2:0] a_row, a_pos, b_row, b_pos, c_row, c_pos;
    logic [4:0] a_bd, b_bd, c_bd;

    int tests = 0;
    int fails = 0;

    ball_dropper #(.ROW_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .auto_en(a_auto), .rand_choice(a_rc),
        .ball_valid(a_bv), .busy(a_busy), .row(a_row), .pos(a_pos),
        .balls_dropped(a_bd), .full(a_full));
    ball_dropper #(.ROW_CYCLES(1)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .auto_en(b_auto), .rand_choice(b_rc),
        .ball_valid(b_bv), .busy(b_busy), .row(b_row), .pos(b_pos),
        .balls_dropped(b_bd), .full(b_full));
    ball_dropper #(.ROW_CYCLES(1), .MAX_BALLS(3), .SEED(16'h0000)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .auto_en(c_auto), .rand_choice(c_rc),
        .ball_valid(c_bv), .busy(c_busy), .row(c_row), .pos(c_pos),
        .balls_dropped(c_bd), .full(c_full));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; a_start = 0; a_auto = 0; b_start = 0; b_auto = 0; c_start = 0; c_auto = 0;
        step();
        step();
        rst = 0;
    endtask

    task automatic check_a_reset_values(input string tag);
        tests += 7;
        if (a_rc !== 7'h00) begin fails++; $display("FAIL %s rand_choice got %h exp 00", tag, a_rc); end
        if (a_bv !== 1'b0) begin fails++; $display("FAIL %s ball_valid got %b exp 0", tag, a_bv); end
        if (a_busy !== 1'b0) begin fails++; $display("FAIL %s busy got %b exp 0", tag, a_busy); end
        if (a_row !== 3'd0) begin fails++; $display("FAIL %s row got %0d exp 0", tag, a_row); end
        if (a_pos !== 3'd0) begin fails++; $display("FAIL %s pos got %0d exp 0", tag, a_pos); end
        if (a_bd !== 5'd0) begin fails++; $display("FAIL %s balls_dropped got %0d exp 0", tag, a_bd); end
        if (a_full !== 1'b0) begin fails++; $display("FAIL %s full got %b exp 0", tag, a_full); end
    endtask

    task automatic test_reset();
        do_reset();
        check_a_reset_values("reset");
    endtask

    task automatic test_single_drop();
        int pos_tab[7] = '{0, 1, 1, 1, 1, 1, 2};
        logic [2:0] er, ep;
        logic ebv, ebusy;
        logic [4:0] ebd;
        do_reset();
        a_start = 1;
        step();
        a_start = 0;
        for (int c = 1; c <= 16; c++) begin
            er    = c <= 14 ? 3'((c - 1) / 2) : 3'd0;
            ep    = c <= 14 ? 3'(pos_tab[(c - 1) / 2]) : c == 15 ? 3'd3 : 3'd0;
            ebv   = c == 15;
            ebusy = c <= 15;
            ebd   = c == 16 ? 5'd1 : 5'd0;
            tests += 6;
            if (a_row !== er) begin fails++; $display("FAIL single row c=%0d got %0d exp %0d", c, a_row, er); end
            if (a_pos !== ep) begin fails++; $display("FAIL single pos c=%0d got %0d exp %0d", c, a_pos, ep); end
            if (a_bv !== ebv) begin fails++; $display("FAIL single ball_valid c=%0d got %b exp %b", c, a_bv, ebv); end
            if (a_busy !== ebusy) begin fails++; $display("FAIL single busy c=%0d got %b exp %b", c, a_busy, ebusy); end
            if (a_bd !== ebd) begin fails++; $display("FAIL single balls_dropped c=%0d got %0d exp %0d", c, a_bd, ebd); end
            if (a_rc !== 7'h61) begin fails++; $display("FAIL single rand_choice c=%0d got %h exp 61", c, a_rc); end
            step();
        end
    endtask

    task automatic test_busy_ignore();
        int pulses = 0;
        do_reset();
        a_start = 1;
        step();
        for (int c = 1; c <= 30; c++) begin
            a_start = c == 5;
            if (a_bv === 1'b1) pulses++;
            step();
        end
        a_start = 0;
        tests += 3;
        if (pulses != 1) begin fails++; $display("FAIL busy_ignore pulses got %0d exp 1", pulses); end
        if (a_bd !== 5'd1) begin fails++; $display("FAIL busy_ignore balls_dropped got %0d exp 1", a_bd); end
        if (a_busy !== 1'b0) begin fails++; $display("FAIL busy_ignore busy got %b exp 0", a_busy); end
    endtask

    task automatic test_auto();
        logic ebv;
        do_reset();
        b_auto = 1;
        for (int c = 0; c <= 35; c++) begin
            ebv = c == 8 || c == 17 || c == 26 || c == 35;
            tests++;
            if (b_bv !== ebv) begin fails++; $display("FAIL auto ball_valid c=%0d got %b exp %b", c, b_bv, ebv); end
            if (ebv) begin
                tests++;
                if (b_pos !== 3'($countones(b_rc))) begin
                    fails++; $display("FAIL auto pos c=%0d got %0d exp %0d", c, b_pos, $countones(b_rc));
                end
            end
            if (c == 8) begin
                tests++;
                if (b_rc !== 7'h61) begin fails++; $display("FAIL auto first path got %h exp 61", b_rc); end
            end
            step();
        end
        tests++;
        if (b_bd !== 5'd4) begin fails++; $display("FAIL auto balls_dropped got %0d exp 4", b_bd); end
        b_auto = 0;
    endtask

    task automatic test_saturation();
        int pulses = 0;
        int bad = 0;
        do_reset();
        c_auto = 1;
        for (int c = 0; c < 60; c++) begin
            if (c_bv === 1'b1) pulses++;
            if (c == 26) begin
                tests++;
                if (c_full !== 1'b0) begin fails++; $display("FAIL sat full_early got %b exp 0", c_full); end
            end
            if (c >= 27 && (c_full !== 1'b1 || c_busy !== 1'b0)) bad++;
            step();
        end
        tests += 3;
        if (pulses != 3) begin fails++; $display("FAIL sat pulses got %0d exp 3", pulses); end
        if (c_bd !== 5'd3) begin fails++; $display("FAIL sat balls_dropped got %0d exp 3", c_bd); end
        if (bad != 0) begin fails++; $display("FAIL sat full_busy bad_cycles got %0d exp 0", bad); end
        c_auto = 0;
    endtask

    task automatic test_reset_mid_flight();
        int pulses = 0;
        do_reset();
        a_start = 1;
        step();
        a_start = 0;
        for (int c = 1; c < 7; c++) step();
        tests++;
        if (a_row !== 3'd3) begin fails++; $display("FAIL midrst row_before got %0d exp 3", a_row); end
        rst = 1;
        step();
        rst = 0;
        check_a_reset_values("midrst");
        a_start = 1;
        step();
        a_start = 0;
        tests += 2;
        if (a_rc !== 7'h61) begin fails++; $display("FAIL midrst relaunch path got %h exp 61", a_rc); end
        if (a_busy !== 1'b1) begin fails++; $display("FAIL midrst relaunch busy got %b exp 1", a_busy); end
        for (int c = 1; c <= 16; c++) begin
            if (a_bv === 1'b1) pulses++;
            step();
        end
        tests++;
        if (pulses != 1) begin fails++; $display("FAIL midrst pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_zero_seed();
        int zeros = 0;
        do_reset();
        tests++;
        if (u_c.u_lfsr.q !== 16'hACE1) begin fails++; $display("FAIL zseed lfsr_reset got %h exp ace1", u_c.u_lfsr.q); end
        c_start = 1;
        step();
        c_start = 0;
        tests++;
        if (c_rc !== 7'h61) begin fails++; $display("FAIL zseed path got %h exp 61", c_rc); end
        for (int c = 0; c < 200; c++) begin
            if (u_c.u_lfsr.q === 16'h0000) zeros++;
            step();
        end
        tests++;
        if (zeros != 0) begin fails++; $display("FAIL zseed lfsr_zero cycles got %0d exp 0", zeros); end
    endtask

    initial begin
        test_reset();
        test_single_drop();
        test_busy_ignore();
        test_auto();
        test_saturation();
        test_reset_mid_flight();
        test_zero_seed();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ball_dropper.md
# ball_dropper

Upstream source stage for the Plinko board bin counter. It generates pseudo-random 7-bit peg paths from a free-running 16-bit LFSR and animates each ball falling row by row. On landing it issues a one-cycle `ball_valid` strobe with the path on `rand_choice`, which the bin counter consumes. It also limits the total number of drops so that no 5-bit bin counter can wrap.

## Interface
- `ROW_CYCLES`, default 4: clock cycles the ball spends on each peg row; must be ≥1.
- `MAX_BALLS`, default 31: total drops allowed before `full`; must be ≤31.
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: single-ball drop request, level-sampled.
- `auto_en` in 1: continuous drop mode.
- `rand_choice` out 7: captured path; bit r=1 means the ball went right at row r.
- `ball_valid` out 1: one-cycle strobe; `rand_choice` is final.
- `busy` out 1: a ball is in flight (FALL or LAND).
- `row` out 3: current row 0..6 during FALL; 0 otherwise.
- `pos` out 3: number of right moves so far; the final bin at LAND.
- `balls_dropped` out 5: number of completed drops.
- `full` out 1: `balls_dropped == MAX_BALLS`.

## Operation
- **LFSR**
  - 16-bit Galois, right shift, tap mask 16'hB400.
  - Advances every cycle that is not in reset.
  - On reset it loads `SEED`.
- **FSM states: IDLE, FALL, LAND.**
  - **IDLE:** if `(start | auto_en) & ~full`, capture `lfsr[6:0]` into the path register. Then set `row`=0, clear the row-tick counter, and go to FALL. `start` and `auto_en` high together launch exactly one ball.
  - **FALL:** the tick counter counts 0..ROW_CYCLES-1. At terminal count it clears and `row` increments. When row 6 reaches terminal count, go to LAND.
  - **LAND:** `ball_valid`=1 for exactly one cycle. `balls_dropped` increments at the end of this cycle. Next state is IDLE.
- `start` is ignored while `busy` or `full`. Requests are not queued.
- `pos` = popcount of `path[row-1:0]` during FALL, so it is 0 at row 0. At LAND, `pos` = popcount(path), range 0..7.
- `rand_choice` = path register. It is held stable from capture until the next capture.
- `full` blocks new launches. A ball already in flight always completes. `balls_dropped` never exceeds `MAX_BALLS`. Only `rst` clears it.
- **Reset mid-flight:** the ball is abandoned with no `ball_valid`, and everything returns to reset values.
- **Reset values:** state IDLE, `rand_choice`=0, `ball_valid`=0, `busy`=0, `row`=0, `pos`=0, `balls_dropped`=0, `full`=0 (`MAX_BALLS`≥1), LFSR=`SEED`.

## Timing
- Launch condition sampled in cycle 0:
  - FALL occupies cycles 1..7·ROW_CYCLES.
  - LAND and `ball_valid` occur in cycle 7·ROW_CYCLES+1.
  - IDLE returns in cycle 7·ROW_CYCLES+2.
- `balls_dropped` updates in cycle 7·ROW_CYCLES+2.
- With `auto_en` held high, a new launch can be sampled in the first IDLE cycle. The ball period is 7·ROW_CYCLES+2 cycles.
- The downstream consumer samples `rand_choice` at the clock edge ending the `ball_valid` cycle. No back-pressure is supported.
- All outputs are registered except `full` and `pos`, which are combinational from registers.

## Structure
- **Shared package `plinko_pkg`:**
  - state enum (IDLE/FALL/LAND)
  - `LFSR_TAPS` = 16'hB400
  - `DEFAULT_SEED` = 16'hACE1
  - `NUM_ROWS` = 7
  - `BIN_W` = 3
  - `COUNT_W` = 5
- **Sub-module `lfsr16`:** inputs `clk`, `rst`, `seed`; output `q[15:0]`.
- The FSM, tick counter, popcount and drop counter live in `ball_dropper`.

## Test plan
- **Single drop:** `SEED`=16'hACE1, `ROW_CYCLES`=2; release `rst`, pulse `start` in the first cycle.
  - Expect `rand_choice`=7'h61.
  - Expect `row` stepping 0..6, two cycles each.
  - Expect `ball_valid` only in cycle 15, with `pos`=3.
  - Expect `balls_dropped`=1 in cycle 16.
- **Busy ignore:** pulse `start` again at cycle 5 of the previous scenario. Expect no extra ball and `balls_dropped` still 1.
- **Auto mode:** `ROW_CYCLES`=1, `auto_en`=1 held.
  - Expect `ball_valid` pulses every 9 cycles.
  - Expect `pos` at each LAND to equal popcount(`rand_choice`).
- **Saturation:** `MAX_BALLS`=3, `auto_en`=1. Expect exactly 3 `ball_valid` pulses, then `full`=1, `busy`=0 forever, and `balls_dropped`=3.
- **Reset mid-flight:** assert `rst` at row 3 for one cycle.
  - Expect no `ball_valid` and all outputs at reset values.
  - Expect the LFSR to reload 16'hACE1, so the next `start` reproduces 7'h61.
- **Zero seed:** `SEED`=0. Expect LFSR never 0 and the first captured path equal to 7'h61.
